uio_bus_arbiter: RTL

Shares the 8-bit bidirectional `uio` pad bus of the `tt_um_toivoh_test` top level between two internal requesters. It grants the bus round-robin, inserts turnaround cycles whenever the pad direction flips, and bounds how long one requester holds the bus while the other waits. It sits directly between the core logic and the `uio_in`/`uio_out`/`uio_oe` top-level ports.

---
 rtl/uio_bus_arbiter_if.sv | 15 +
 rtl/uio_bus_arbiter.sv | 87 ++++++++
 2 files changed

// File: rtl/uio_bus_arbiter_if.sv
// uio_bus_arbiter_if: requester handshake and uio pad bus shared between core logic and arbiter.
interface uio_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] wr;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master (output req, wr, wdata0, wdata1, uio_in, input gnt, ack, rdata, uio_out, uio_oe);
  modport slave (input req, wr, wdata0, wdata1, uio_in, output gnt, ack, rdata, uio_out, uio_oe);
endinterface

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin sharing of the uio pad bus between two requesters,
// with turnaround on direction change and a bounded hold while the other waits.
module uio_bus_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD = 4
) (
  input logic clk,
  input logic rst,
  input logic ena,
  uio_bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;
  state_t r_state;
  logic r_owner;
  logic r_last_owner;
  logic r_dir;
  logic [TW-1:0] r_turn;
  logic [CW-1:0] r_beats;
  logic [1:0] r_ack;
  logic [7:0] r_rdata;
  logic w_win;
  logic w_beat;
  logic w_drive;
  logic [1:0] w_onehot;
  logic [7:0] w_wdata;
  logic [CW-1:0] w_beats_nx;
  // A tie goes to whoever did not own the bus last.
  assign w_win = (bus.req == 2'b11) ? ~r_last_owner : bus.req[1];
  assign w_onehot = {r_owner, ~r_owner};
  assign w_wdata = r_owner ? bus.wdata1 : bus.wdata0;
  assign w_beat = (r_state == XFER) && ena && bus.req[r_owner] && (bus.wr[r_owner] == r_dir);
  assign w_drive = w_beat && r_dir;
  assign w_beats_nx = (r_beats == CW'(MAX_HOLD)) ? r_beats : r_beats + CW'(1);
  assign bus.gnt = (r_state == XFER) ? w_onehot : 2'b00;
  assign bus.uio_oe = w_drive ? 8'hFF : 8'h00;
  assign bus.uio_out = w_drive ? w_wdata : 8'h00;
  assign bus.ack = r_ack;
  assign bus.rdata = r_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last_owner <= 1'b1;
      r_dir <= 1'b0;
      r_turn <= '0;
      r_beats <= '0;
      r_ack <= 2'b00;
      r_rdata <= 8'h00;
    end else begin
      r_ack <= 2'b00;
      case (r_state)
        IDLE: if (ena && |bus.req) begin
          r_owner <= w_win;
          if (bus.wr[w_win] == r_dir) r_state <= XFER;
          else begin
            r_dir <= bus.wr[w_win];
            r_turn <= TW'(TURN_CYCLES);
            r_state <= TURN;
          end
        end
        TURN: if (!ena || !bus.req[r_owner]) begin
          r_state <= IDLE;
          r_last_owner <= r_owner;
        end else if (r_turn == TW'(1)) r_state <= XFER;
        else r_turn <= r_turn - TW'(1);
        XFER: if (w_beat) begin
          r_ack <= w_onehot;
          if (!r_dir) r_rdata <= bus.uio_in;
          r_beats <= w_beats_nx;
          // Yield only once the hold budget is spent and the other side is waiting.
          if (w_beats_nx == CW'(MAX_HOLD) && bus.req[~r_owner]) begin
            r_state <= IDLE;
            r_last_owner <= r_owner;
            r_beats <= '0;
          end
        end else begin
          r_state <= IDLE;
          r_last_owner <= r_owner;
          r_beats <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
